// File: rtl/display_scheduler_pkg.sv
// Shared types and helpers for the display scheduler.
package display_scheduler_pkg;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 16;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        FREEZE = 2'd2
    } state_t;

    // Next valid source after cur, scanning round-robin (wrapping 3->0).
    // Returns cur unchanged when no other source is valid.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur,
                                                   input logic [NUM_SRC-1:0] valid);
        logic [SEL_W-1:0] cand;
        next_sel = cur;
        // Walk from the farthest offset to the nearest so the nearest wins.
        for (int i = NUM_SRC - 1; i >= 1; i--) begin
            cand = cur + SEL_W'(i);
            if (valid[cand]) next_sel = cand;
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: the stable level follows the raw key only after the
// raw value has differed from it for DEBOUNCE_CYCLES consecutive cycles, and a
// one-cycle pulse marks each debounced rising edge. The raw key is expected to
// be synchronous to clk already.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            pulse <= 1'b0;
            cnt   <= '0;
        end else begin
            pulse <= 1'b0;
            if (key_raw == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= key_raw;
                pulse <= key_raw;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Display scheduler: picks one of four 16-bit sources for a registered
// display word, in MANUAL (key2 steps), AUTO (timed dwell) or FREEZE (hold).
// Optional build macro DISPLAY_SCHEDULER_TAG_EN replaces the top nibble of
// the display word with the selected source index.
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int is_simulation   = 0,
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [3:0]  key_sw_p,
    input  logic [3:0]  src_valid,
    input  logic [63:0] src_data,
    output logic [15:0] display_number,
    output logic [3:0]  led_p
);

    localparam int DWELL_EFF = (is_simulation != 0) ? 16 : DWELL_CYCLES;
    localparam int DEB_EFF   = (is_simulation != 0) ? 4  : DEBOUNCE_CYCLES;
    localparam int DW_W      = (DWELL_EFF > 1) ? $clog2(DWELL_EFF) : 1;
    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL_EFF - 1);

    logic                          rst;
    logic [2:0]                    key_pulse;
    logic [2:0]                    unused_key_level;
    logic                          k1_pulse, k2_pulse, k3_pulse;
    state_t                        state, state_next, frozen_from;
    logic [SEL_W-1:0]              sel;
    logic [DW_W-1:0]               dwell;
    logic [NUM_SRC-1:0][SRC_W-1:0] src_words;
    logic [SRC_W-1:0]              cur_word;

    assign src_words = src_data;
    assign cur_word  = src_words[sel];
    assign k1_pulse  = key_pulse[0];
    assign k2_pulse  = key_pulse[1];
    assign k3_pulse  = key_pulse[2];

    // Combined reset (external or key0), registered so it lands one cycle later.
    always_ff @(posedge clk) begin
        rst <= reset_p | key_sw_p[0];
    end

    // One debouncer per mode key (key1..key3).
    for (genvar k = 1; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEB_EFF)
        ) u_key (
            .clk    (clk),
            .rst    (rst),
            .key_raw(key_sw_p[k]),
            .level  (unused_key_level[k-1]),
            .pulse  (key_pulse[k-1])
        );
    end

    // Mode transitions; key3 is checked first so it beats a coincident key1.
    always_comb begin
        state_next = state;
        case (state)
            MANUAL: begin
                if (k3_pulse)      state_next = FREEZE;
                else if (k1_pulse) state_next = AUTO;
            end
            AUTO: begin
                if (k3_pulse)      state_next = FREEZE;
                else if (k1_pulse) state_next = MANUAL;
            end
            FREEZE: begin
                if (k3_pulse)      state_next = frozen_from;
            end
            default: state_next = MANUAL;
        endcase
    end

    // State register; remembers which mode was frozen so key3 can return to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MANUAL;
            frozen_from <= MANUAL;
        end else begin
            state <= state_next;
            if (state != FREEZE && state_next == FREEZE) frozen_from <= state;
        end
    end

    // Source selection and dwell timing. The dwell counter is held at zero
    // outside AUTO so every entry into AUTO starts a full dwell period;
    // src_valid changes never touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel   <= '0;
            dwell <= '0;
        end else if (state == AUTO && state_next == AUTO) begin
            if (dwell == DWELL_MAX) begin
                dwell <= '0;
                sel   <= next_sel(sel, src_valid);
            end else begin
                dwell <= dwell + 1'b1;
            end
        end else begin
            if (state != AUTO) dwell <= '0;
            if (state == MANUAL && state_next == MANUAL && k2_pulse)
                sel <= next_sel(sel, src_valid);
        end
    end

    // Registered outputs: follow the selected source unless frozen; an
    // invalid selected source blanks both the word and the LED.
    always_ff @(posedge clk) begin
        if (rst) begin
            display_number <= '0;
            led_p          <= '0;
        end else if (state != FREEZE) begin
            if (src_valid[sel]) begin
`ifdef DISPLAY_SCHEDULER_TAG_EN
                display_number <= {2'b00, sel, cur_word[11:0]};
`else
                display_number <= cur_word;
`endif
                led_p <= 4'b0001 << sel;
            end else begin
                display_number <= '0;
                led_p          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler in simulation timing (debounce 4,
// dwell 16). Inputs change 1 time unit after a rising edge; outputs are
// checked at the same point after the edge they depend on.
module tb_display_scheduler;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [3:0]  key_sw_p;
    logic [3:0]  src_valid;
    logic [63:0] src_data;
    logic [15:0] display_number;
    logic [3:0]  led_p;

    int n_assert = 0;
    int n_fail   = 0;

    display_scheduler #(.is_simulation(1)) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .key_sw_p      (key_sw_p),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .display_number(display_number),
        .led_p         (led_p)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold key k high for n cycles, release, then let the release settle.
    task automatic press(input int k, input int n);
        key_sw_p[k] = 1'b1;
        tick(n);
        key_sw_p[k] = 1'b0;
        tick(6);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_p   = 1'b1;
        key_sw_p  = 4'b0000;
        src_valid = 4'b1111;
        src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        tick(3);
        check("reset_disp", display_number, 16'h0000);
        check("reset_led",  {12'd0, led_p}, 16'h0000);

        reset_p = 1'b0;
        tick(2);
        check("manual_disp0", display_number, 16'h1111);
        check("manual_led0",  {12'd0, led_p}, 16'h0001);
        tick(10);
        check("manual_hold", display_number, 16'h1111);

        // Four-cycle press gives exactly one advance.
        press(2, 4);
        check("key2_disp", display_number, 16'h2222);
        check("key2_led",  {12'd0, led_p}, 16'h0002);
        tick(20);
        check("key2_single", display_number, 16'h2222);
        // Three-cycle glitch is filtered.
        press(2, 3);
        check("glitch", display_number, 16'h2222);

        // No valid source: blank outputs, key2 keeps sel.
        src_valid = 4'b0000;
        tick(1);
        check("none_disp", display_number, 16'h0000);
        check("none_led",  {12'd0, led_p}, 16'h0000);
        press(2, 4);
        src_valid = 4'b0010;
        tick(1);
        check("none_sel_kept", display_number, 16'h2222);

        // Round-robin over 0101: 1 -> 2 -> (3 invalid) -> 0.
        src_valid = 4'b0101;
        tick(1);
        check("invalid_sel", display_number, 16'h0000);
        press(2, 4);
        check("rr_to2", display_number, 16'h3333);
        press(2, 4);
        check("rr_wrap", display_number, 16'h1111);
        check("rr_wrap_led", {12'd0, led_p}, 16'h0001);

        // key1 -> AUTO: 16 cycles per source.
        key_sw_p[1] = 1'b1;
        tick(4);
        key_sw_p[1] = 1'b0;
        tick(1);
        tick(16);
        check("auto_dwell0_end", display_number, 16'h1111);
        tick(1);
        check("auto_to2", display_number, 16'h3333);
        check("auto_to2_led", {12'd0, led_p}, 16'h0004);
        tick(15);
        check("auto_dwell2_end", display_number, 16'h3333);
        tick(1);
        check("auto_to0", display_number, 16'h1111);
        check("auto_to0_led", {12'd0, led_p}, 16'h0001);

        // key3 -> FREEZE; data changes and key1/key2 are ignored.
        key_sw_p[3] = 1'b1;
        tick(4);
        key_sw_p[3] = 1'b0;
        tick(1);
        src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        press(2, 4);
        press(1, 4);
        tick(100);
        check("freeze_disp", display_number, 16'h1111);
        check("freeze_led",  {12'd0, led_p}, 16'h0001);

        // Second key3 resumes AUTO with a fresh dwell.
        key_sw_p[3] = 1'b1;
        tick(4);
        key_sw_p[3] = 1'b0;
        tick(1);
        tick(1);
        check("resume_disp", display_number, 16'hAAAA);
        tick(16);
        check("resume_adv", display_number, 16'hCCCC);
        check("resume_adv_led", {12'd0, led_p}, 16'h0004);

        // key1 and key3 together: freeze wins.
        key_sw_p[1] = 1'b1;
        key_sw_p[3] = 1'b1;
        tick(4);
        key_sw_p[1] = 1'b0;
        key_sw_p[3] = 1'b0;
        tick(1);
        src_data = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
        tick(40);
        check("prio_freeze", display_number, 16'hCCCC);
        press(3, 4);
        check("prio_back_auto", display_number, 16'h7777);

        // key0 mid-dwell: reset one cycle later, back in MANUAL at sel 0.
        key_sw_p[0] = 1'b1;
        tick(1);
        key_sw_p[0] = 1'b0;
        tick(1);
        check("key0_disp", display_number, 16'h0000);
        check("key0_led",  {12'd0, led_p}, 16'h0000);
        tick(1);
        check("key0_after", display_number, 16'h5555);
        check("key0_after_led", {12'd0, led_p}, 16'h0001);
        tick(40);
        check("key0_manual", display_number, 16'h5555);

        // Reset landing with a key2 pulse overrides the advance.
        key_sw_p[2] = 1'b1;
        tick(3);
        key_sw_p[0] = 1'b1;
        tick(1);
        key_sw_p[0] = 1'b0;
        key_sw_p[2] = 1'b0;
        tick(1);
        tick(6);
        check("rst_override", display_number, 16'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
